imem_bank: RTL and testbench

Parametrised, byte-addressed instruction memory with a registered fetch port and a byte-enabled load port. It replaces the fixed 32-bit/4000-byte instruction store in the fetch stage. The memory array cannot be cleared inside an asynchronous reset, so a sequenced clear engine zeroes it instead. Misaligned and out-of-range accesses are reported rather than silently wrapping.

---
 rtl/imem_bank.sv | 164 ++++++++++++++++
 tb/tb_imem_bank.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_bank.sv
// Byte-addressed instruction memory: registered big-endian fetch port, byte-enabled
// load port, and a sequenced clear engine that zeroes the array after reset or on request.
module imem_bank #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_BYTES = 4000,
   parameter int ADDR_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   output logic                  busy,
   input  logic                  fetch_req,
   input  logic [ADDR_W-1:0]     fetch_addr,
   output logic                  fetch_valid,
   output logic [DATA_W-1:0]     instruction,
   output logic                  fetch_fault,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W/8-1:0]   wr_be,
   output logic                  wr_ack,
   output logic                  wr_fault
);

   localparam int WB    = DATA_W / 8;
   localparam int WORDS = DEPTH_BYTES / WB;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [ADDR_W-1:0] WB_A      = ADDR_W'(WB);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_BYTES - WB);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;

   // Misaligned or past the last whole word: reported, never wrapped.
   function automatic logic f_addr_fault(input logic [ADDR_W-1:0] addr);
      return ((addr % WB_A) != {ADDR_W{1'b0}}) || (addr > LAST_ADDR);
   endfunction

   logic [DATA_W-1:0] r_mem [0:WORDS-1];

   logic [1:0]        r_state;
   logic [IDX_W-1:0]  r_clr_idx;
   logic              r_busy;
   logic              r_fetch_valid;
   logic              r_fetch_fault;
   logic [DATA_W-1:0] r_instruction;
   logic              r_wr_ack;
   logic              r_wr_fault;

   logic [1:0]        w_state_nxt;
   logic [IDX_W-1:0]  w_clr_idx_nxt;
   logic              w_mem_we;
   logic [IDX_W-1:0]  w_mem_idx;
   logic [DATA_W-1:0] w_mem_wdata;
   logic [WB-1:0]     w_mem_be;

   logic              w_fetch_fault;
   logic              w_wr_fault;
   logic [IDX_W-1:0]  w_fetch_idx;
   logic [IDX_W-1:0]  w_wr_idx;
   logic              w_accept;
   logic              w_fetch_go;
   logic              w_wr_go;

   assign w_fetch_fault = f_addr_fault(fetch_addr);
   assign w_wr_fault    = f_addr_fault(wr_addr);
   assign w_fetch_idx   = IDX_W'(fetch_addr / WB_A);
   assign w_wr_idx      = IDX_W'(wr_addr / WB_A);

   // clear in IDLE takes priority and silently drops same-cycle requests.
   assign w_accept   = (r_state == ST_IDLE) && !clear;
   assign w_fetch_go = w_accept && fetch_req;
   assign w_wr_go    = w_accept && wr_en;

   // Next-state, sweep counter and single shared array write port.
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_idx_nxt = r_clr_idx;
      w_mem_we      = 1'b0;
      w_mem_idx     = r_clr_idx;
      w_mem_wdata   = {DATA_W{1'b0}};
      w_mem_be      = {WB{1'b0}};
      case (r_state)
         ST_CLEAR: begin
            w_mem_we  = 1'b1;
            w_mem_idx = r_clr_idx;
            w_mem_be  = {WB{1'b1}};
            if (r_clr_idx == LAST_IDX) begin
               w_state_nxt   = ST_IDLE;
               w_clr_idx_nxt = {IDX_W{1'b0}};
            end else begin
               w_clr_idx_nxt = r_clr_idx + IDX_W'(1);
            end
         end
         ST_IDLE: begin
            if (clear) begin
               w_state_nxt   = ST_CLEAR;
               w_clr_idx_nxt = {IDX_W{1'b0}};
            end else begin
               w_mem_we    = w_wr_go && !w_wr_fault;
               w_mem_idx   = w_wr_idx;
               w_mem_wdata = wr_data;
               w_mem_be    = wr_be;
            end
         end
         default: begin
            w_state_nxt   = ST_CLEAR;
            w_clr_idx_nxt = {IDX_W{1'b0}};
         end
      endcase
   end

   // Array write, byte lane k holds bits [8k+7:8k]; no reset on the storage itself.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int k = 0; k < WB; k++) begin
            if (w_mem_be[k]) begin
               r_mem[w_mem_idx][8*k +: 8] <= w_mem_wdata[8*k +: 8];
            end
         end
      end
   end

   // Control state and registered responses; the fetch reads the pre-write word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_CLEAR;
         r_clr_idx     <= {IDX_W{1'b0}};
         r_busy        <= 1'b1;
         r_fetch_valid <= 1'b0;
         r_fetch_fault <= 1'b0;
         r_instruction <= {DATA_W{1'b0}};
         r_wr_ack      <= 1'b0;
         r_wr_fault    <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_clr_idx     <= w_clr_idx_nxt;
         r_busy        <= (w_state_nxt == ST_CLEAR);
         r_fetch_valid <= w_fetch_go;
         r_fetch_fault <= w_fetch_go && w_fetch_fault;
         r_wr_ack      <= w_wr_go;
         r_wr_fault    <= w_wr_go && w_wr_fault;
         if (w_fetch_go) begin
            if (w_fetch_fault) begin
               r_instruction <= {DATA_W{1'b0}};
            end else begin
               r_instruction <= r_mem[w_fetch_idx];
            end
         end else begin
            r_instruction <= r_instruction;
         end
      end
   end

   assign busy        = r_busy;
   assign fetch_valid = r_fetch_valid;
   assign fetch_fault = r_fetch_fault;
   assign instruction = r_instruction;
   assign wr_ack      = r_wr_ack;
   assign wr_fault    = r_wr_fault;

endmodule

// File: tb/tb_imem_bank.sv
// Scoreboard bench for imem_bank: byte-array reference model, decoupled monitor.
module tb_imem_bank;

   localparam int DW = 32;
   localparam int DB = 4000;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          clear;
   logic          busy;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic          fetch_valid;
   logic [DW-1:0] instruction;
   logic          fetch_fault;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [3:0]    wr_be;
   logic          wr_ack;
   logic          wr_fault;

   always #5 clk = ~clk;

   imem_bank #(.DATA_W(DW), .DEPTH_BYTES(DB), .ADDR_W(AW)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .busy(busy),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
      .instruction(instruction), .fetch_fault(fetch_fault),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .wr_ack(wr_ack), .wr_fault(wr_fault)
   );

   typedef struct {
      logic [31:0] instr;
      logic        fault;
   } fexp_t;

   fexp_t       fq[$];
   logic        wq[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [7:0]  mdl [DB];
   logic [31:0] exp_last;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic mdl_fault(input logic [31:0] a);
      return (a % 32'd4 != 32'd0) || (a > 32'(DB - 4));
   endfunction

   // Byte at the lowest address is the most significant byte.
   function automatic logic [31:0] mdl_read(input logic [31:0] a);
      return {mdl[a], mdl[a + 32'd1], mdl[a + 32'd2], mdl[a + 32'd3]};
   endfunction

   task automatic mdl_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      for (int j = 0; j < 4; j++) begin
         if (be[3 - j]) mdl[a + 32'(j)] = wd[31 - 8*j -: 8];
      end
   endtask

   task automatic mdl_zero();
      for (int i = 0; i < DB; i++) mdl[i] = 8'h00;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one request cycle (assumed idle) and records the expected responses.
   task automatic req(input logic fr, input logic [31:0] fa, input logic we,
                      input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] be,
                      input logic cl);
      fexp_t e;
      fetch_req = fr; fetch_addr = fa;
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
      clear = cl;
      if (cl) begin
         mdl_zero();
      end else begin
         if (fr) begin
            e.fault = mdl_fault(fa);
            e.instr = e.fault ? 32'h0 : mdl_read(fa);
            fq.push_back(e);
         end
         if (we) begin
            wq.push_back(mdl_fault(wa));
            if (!mdl_fault(wa)) mdl_write(wa, wd, be);
         end
      end
      step();
      fetch_req = 1'b0; wr_en = 1'b0; clear = 1'b0;
   endtask

   task automatic fetch_expect(input string name, input logic [31:0] a,
                               input logic [31:0] val, input logic flt);
      req(1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      chk({name, "_valid"}, 64'(fetch_valid), 64'd1);
      chk({name, "_data"}, 64'(instruction), 64'(val));
      chk({name, "_fault"}, 64'(fetch_fault), 64'(flt));
      step();
   endtask

   task automatic write_expect(input string name, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic flt);
      req(1'b0, 32'h0, 1'b1, a, d, be, 1'b0);
      @(negedge clk);
      chk({name, "_ack"}, 64'(wr_ack), 64'd1);
      chk({name, "_fault"}, 64'(wr_fault), 64'(flt));
      step();
   endtask

   task automatic wait_sweep(input string name);
      int n = 0;
      while (busy && n < 3000) begin
         step();
         n++;
      end
      chk(name, 64'(n), 64'd1000);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_busy"}, 64'(busy), 64'd1);
      chk({name, "_fv"}, 64'(fetch_valid), 64'd0);
      chk({name, "_instr"}, 64'(instruction), 64'd0);
      chk({name, "_ff"}, 64'(fetch_fault), 64'd0);
      chk({name, "_ack"}, 64'(wr_ack), 64'd0);
      chk({name, "_wf"}, 64'(wr_fault), 64'd0);
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = 32'($urandom_range(0, 1003)) * 32'd4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      return a;
   endfunction

   // Monitor: pops the scoreboard whenever a response pulse appears.
   initial begin
      fexp_t e;
      logic  wf;
      exp_last = 32'h0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            exp_last = 32'h0;
         end else begin
            if (fetch_valid) begin
               if (fq.size() == 0) begin
                  chk("fetch_spurious", 64'(fetch_valid), 64'd0);
               end else begin
                  e = fq.pop_front();
                  chk("sb_fetch_data", 64'(instruction), 64'(e.instr));
                  chk("sb_fetch_fault", 64'(fetch_fault), 64'(e.fault));
                  exp_last = e.instr;
               end
            end else begin
               chk("instr_hold", 64'(instruction), 64'(exp_last));
               chk("fault_no_valid", 64'(fetch_fault), 64'd0);
            end
            if (wr_ack) begin
               if (wq.size() == 0) begin
                  chk("wr_spurious", 64'(wr_ack), 64'd0);
               end else begin
                  wf = wq.pop_front();
                  chk("sb_wr_fault", 64'(wr_fault), 64'(wf));
               end
            end else begin
               chk("wr_fault_no_ack", 64'(wr_fault), 64'd0);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
      $fatal(1);
   end

   initial begin
      logic [31:0] fa, wa, wd;
      int          op;
      reset_n = 1'b1;
      clear = 1'b0; fetch_req = 1'b0; fetch_addr = 32'h0;
      wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0; wr_be = 4'h0;
      mdl_zero();
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      wait_sweep("sweep_len_reset");

      fetch_expect("fetch0", 32'h000, 32'h0, 1'b0);
      write_expect("wr_dead", 32'h010, 32'hDEADBEEF, 4'hF, 1'b0);
      fetch_expect("fetch10", 32'h010, 32'hDEADBEEF, 1'b0);
      fetch_expect("fetch11", 32'h011, 32'h0, 1'b1);

      write_expect("wr_base20", 32'h020, 32'h11223344, 4'hF, 1'b0);
      write_expect("wr_be20", 32'h020, 32'hAABBCCDD, 4'b0101, 1'b0);
      fetch_expect("fetch20", 32'h020, 32'h11BB33DD, 1'b0);

      write_expect("wr_last", 32'hF9C, 32'hCAFEF00D, 4'hF, 1'b0);
      fetch_expect("fetch_last", 32'hF9C, 32'hCAFEF00D, 1'b0);
      write_expect("wr_oob", 32'hFA0, 32'h01020304, 4'hF, 1'b1);
      fetch_expect("fetch_oob", 32'hFA0, 32'h0, 1'b1);
      fetch_expect("fetch_last2", 32'hF9C, 32'hCAFEF00D, 1'b0);

      write_expect("wr_old30", 32'h030, 32'h12345678, 4'hF, 1'b0);
      req(1'b1, 32'h030, 1'b1, 32'h030, 32'h55555555, 4'hF, 1'b0);
      @(negedge clk);
      chk("collide_old", 64'(instruction), 64'h12345678);
      chk("collide_ack", 64'(wr_ack), 64'd1);
      step();
      fetch_expect("collide_new", 32'h030, 32'h55555555, 1'b0);

      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 3);
         fa = rnd_addr();
         wa = rnd_addr();
         wd = $urandom;
         if (op == 2 && $urandom_range(0, 3) == 0) wa = fa;
         if (op == 3) step();
         else req(op != 1, fa, op != 0, wa, wd, 4'($urandom_range(0, 15)), 1'b0);
      end
      step();

      req(1'b1, 32'h030, 1'b1, 32'h030, 32'h77777777, 4'hF, 1'b1);
      chk("clear_busy", 64'(busy), 64'd1);
      wait_sweep("sweep_len_clear");
      fetch_expect("after_clear30", 32'h030, 32'h0, 1'b0);
      fetch_expect("after_clear_last", 32'hF9C, 32'h0, 1'b0);

      req(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      repeat (500) step();
      chk("mid_sweep_busy", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("mid_sweep_reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      wait_sweep("sweep_len_restart");

      write_expect("wr_pre_rst", 32'h040, 32'hA5A5A5A5, 4'hF, 1'b0);
      req(1'b1, 32'h040, 1'b1, 32'h044, 32'h5A5A5A5A, 4'hF, 1'b0);
      reset_n = 1'b0;
      fq.delete();
      wq.delete();
      mdl_zero();
      #1;
      check_reset_outputs("mid_access_reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      wait_sweep("sweep_len_access");
      fetch_expect("after_rst40", 32'h040, 32'h0, 1'b0);

      repeat (3) step();
      chk("fetch_drain", 64'(fq.size()), 64'd0);
      chk("wr_drain", 64'(wq.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
